// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter: FSM state encoding,
// width helper and the supported requester-count ceiling.
package arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam int MAX_N = 16;

  // Constant-evaluable ceil(log2(value)); returns 0 for value <= 1.
  function automatic int arb_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: finds the first set bit of vec searching
// upward from index start, wrapping modulo N. Purely combinational.
module rr_pick
  import arb_pkg::*;
#(
  parameter  int N   = 4,
  localparam int IDW = arb_clog2(N)
) (
  input  logic [N-1:0]   vec,
  input  logic [IDW-1:0] start,
  output logic [N-1:0]   onehot,
  output logic [IDW-1:0] idx,
  output logic           found
);

  // NOTE: every output gets a default before the loop so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!found && vec[(int'(start) + k) % N]) begin
        found                       = 1'b1;
        idx                         = IDW'((int'(start) + k) % N);
        onehot[(int'(start) + k) % N] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_param.sv
// N-requester round-robin arbiter with registered one-hot grant, grant
// hold and hold timeout. Optional urgent preemption: RR_ARB_URGENT_EN.
module rr_arbiter_param
  import arb_pkg::*;
#(
  parameter  int N        = 4,
  parameter  int MAX_HOLD = 4,
  localparam int IDW      = arb_clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
`ifdef RR_ARB_URGENT_EN
  input  logic [N-1:0]   urgent,
`endif
  output logic [N-1:0]   grant,
  output logic           grant_valid,
  output logic [IDW-1:0] grant_id
);

  localparam int HCW = (MAX_HOLD < 2) ? 1 : arb_clog2(MAX_HOLD + 1);

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [HCW-1:0] hold_q, hold_d;
  logic [N-1:0]   grant_d;
  logic [IDW-1:0] id_d;

  // Candidate set the FSM arbitrates over this cycle and its pick from ptr.
  logic [N-1:0]   act;
  logic [N-1:0]   pick_oh;
  logic [IDW-1:0] pick_idx;
  logic           pick_found;

  logic [N-1:0]   n_oh;
  logic [IDW-1:0] n_idx;
  logic           n_found;

  rr_pick #(.N(N)) u_pick_norm (
    .vec    (req),
    .start  (ptr_q),
    .onehot (n_oh),
    .idx    (n_idx),
    .found  (n_found)
  );

`ifdef RR_ARB_URGENT_EN
  logic [N-1:0]   urg_vec;
  logic [N-1:0]   u_oh;
  logic [IDW-1:0] u_idx;
  logic           u_found;

  assign urg_vec = req & urgent;

  rr_pick #(.N(N)) u_pick_urg (
    .vec    (urg_vec),
    .start  (ptr_q),
    .onehot (u_oh),
    .idx    (u_idx),
    .found  (u_found)
  );

  // Any urgent request narrows arbitration to the urgent set; a plain
  // owner then looks released and is preempted through the release path.
  assign act        = u_found ? urg_vec : req;
  assign pick_oh    = u_found ? u_oh    : n_oh;
  assign pick_idx   = u_found ? u_idx   : n_idx;
  assign pick_found = u_found | n_found;
`else
  assign act        = req;
  assign pick_oh    = n_oh;
  assign pick_idx   = n_idx;
  assign pick_found = n_found;
`endif

  logic own_req;
  logic other_req;

  // ptr already sits one past the owner, so a pick from ptr only returns
  // the owner when nobody else in the candidate set is requesting.
  assign own_req   = act[grant_id];
  assign other_req = pick_found && (pick_idx != grant_id);

  always_comb begin
    state_d = state_q;
    grant_d = grant;
    id_d    = grant_id;
    hold_d  = hold_q;
    ptr_d   = ptr_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d = ARB_BUSY;
          grant_d = pick_oh;
          id_d    = pick_idx;
          hold_d  = HCW'(1);
        end
      end
      ARB_BUSY: begin
        if (own_req && (MAX_HOLD == 0 || hold_q < HCW'(MAX_HOLD))) begin
          if (hold_q != '1) hold_d = hold_q + 1'b1;
        end else if (own_req) begin
          hold_d = HCW'(1);
          if (other_req) begin
            grant_d = pick_oh;
            id_d    = pick_idx;
          end
        end else if (pick_found) begin
          grant_d = pick_oh;
          id_d    = pick_idx;
          hold_d  = HCW'(1);
        end else begin
          state_d = ARB_IDLE;
          grant_d = '0;
          id_d    = '0;
          hold_d  = '0;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    if (state_d == ARB_BUSY)
      ptr_d = (id_d == IDW'(N - 1)) ? '0 : id_d + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ARB_IDLE;
      ptr_q       <= '0;
      hold_q      <= '0;
      grant       <= '0;
      grant_valid <= 1'b0;
      grant_id    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
      grant       <= grant_d;
      grant_valid <= |grant_d;
      grant_id    <= id_d;
    end
  end

endmodule

// File: doc/rr_arbiter_param.md
Name: rr_arbiter_param

Overview:
- N-requester round-robin arbiter with registered one-hot grant, grant-hold while request stays high, and a hold-timeout that forces rotation.
- Successor to the fixed 3-channel round-robin arbiter; generalised in channel count and burst length.
- Sits in front of any shared resource (bus, memory port, shared FIFO); requesters hold req until served and drop it when done.

Parameters:
- N, 4, number of requesters; legal range 2..16.
- MAX_HOLD, 4, maximum consecutive cycles one owner keeps the grant while others wait. 0 = unlimited. 1 = rotate every cycle (legacy behaviour).
- IDW, $clog2(N), width of grant_id (localparam, not overridable).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- req  in  N  request vector; bit i = requester i.
- grant  out  N  registered one-hot grant; all-zero when idle.
- grant_valid  out  1  OR of grant, registered.
- grant_id  out  IDW  index of the granted requester; 0 when idle.

Behaviour:
- Reset values (rst=0, async): grant=0, grant_valid=0, grant_id=0, ptr=0, hold_cnt=0, state=IDLE. Release is synchronous to clk in effect; no grant in the first cycle after release.
- ptr = search start. After a grant to channel g, ptr = (g+1) mod N. Search order is ptr, ptr+1, …, wrapping.
- Latency: a request sampled at edge k produces a grant visible after edge k (one registered stage). grant never depends combinationally on req.
- FSM IDLE:
  - If req==0, stay in IDLE.
  - Otherwise grant the first set bit from ptr, load hold_cnt=1, and go to BUSY.
- FSM BUSY with owner g:
  - Keep: req[g]=1 and (MAX_HOLD==0 or hold_cnt<MAX_HOLD) → keep g; hold_cnt++ (saturates).
  - Release: req[g]=0 → pick the next requester from (g+1) with no idle gap; hold_cnt=1. If no other requester, go to IDLE and clear grant.
  - Timeout: hold_cnt==MAX_HOLD and another req bit set → rotate to the next requester from (g+1); hold_cnt=1.
  - Timeout with no other requester → keep g; hold_cnt=1 (window restarts).
- Simultaneous owner drop and new requests: the new grant is decided on the same edge; never grant a channel whose req is 0 at the sampling edge.
- grant is always one-hot or zero. grant_id and grant_valid are consistent with grant on every cycle.
- Reset mid-operation: immediate clear of all outputs and state; ptr returns to 0.

Optional Feature:
- Macro: RR_ARB_URGENT_EN.
- When defined:
  - Adds input `urgent` (N bits). Any req[i]&urgent[i] bit preempts round-robin and plain holding.
  - Among urgent requesters, the search is round-robin from ptr.
  - An urgent owner keeps the grant while its req stays high; MAX_HOLD applies only among urgent competitors.
- When undefined: no port is added and the behaviour is exactly as above.

Decomposition:
- Package arb_pkg:
  - state encoding (ARB_IDLE=1'b0, ARB_BUSY=1'b1);
  - the clog2 helper function;
  - MAX_N=16 limit constant.
- Sub-module rr_pick: purely combinational rotating priority encoder. Inputs: (vec[N], start[IDW]). Outputs: onehot[N], idx[IDW], found. It is instantiated once, or twice with RR_ARB_URGENT_EN (urgent and normal vectors).

Test Plan (N=4, MAX_HOLD=4 unless stated):
- Reset: hold rst=0 with req=4'b1111 → grant=0000, grant_valid=0, grant_id=0. Release → grant=0001 one edge later.
- Single requesters: req=0100 for 3 cycles, then 0000 → grant=0100, id=2, held 3 cycles, then 0000 and FSM back to IDLE.
- Timeout rotation: req=1111 held for 16 cycles → grant 0001×4, 0010×4, 0100×4, 1000×4, then 0001 again.
- Legacy mode MAX_HOLD=1, N=3: req=111 → grants 001, 010, 100, 001 on consecutive cycles.
- Early release / wrap: owner 3 (req=1001) drops bit 3 → next edge grant=0001 with no idle cycle. Lone owner past MAX_HOLD keeps its grant.
- Urgent (RR_ARB_URGENT_EN): owner 0 busy, req=0101, urgent=0100 → grant=0100 on the next edge. When urgent is cleared, round-robin resumes with ptr=3.
